// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PIC16F program counter, instruction register and return stack
//
// Ports:
//   clk, rst              core clock, synchronous active-high reset
//   instr_rd_en           load pm_data into instr_current
//   instr_flush           load NOP into instr_current (wins over instr_rd_en)
//   pc_incr_en            pc <= pc + 1
//   pc_j_en               pc <= {pclath[4:3], instr_current[10:0]}
//   stack_push            push pc onto the return stack
//   stack_pop             pc <= top of stack (wins over jump/increment)
//   pclath                PCLATH register contents
//   pm_data / pm_addr     program-memory read data / address (pm_addr == pc)
//   pc                    program counter
//   instr_current         instruction register to the decoder
//   stack_depth           number of valid return-stack entries, 0..STACK_DEPTH
//   stack_overflow        sticky, push attempted at full depth
//   stack_underflow       sticky, pop attempted at depth 0

module instruction_fetch #(
    parameter int                     PC_WIDTH     = 13,
    parameter int                     STACK_DEPTH  = 8,
    parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = '0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            instr_rd_en,
    input  logic                            instr_flush,
    input  logic                            pc_incr_en,
    input  logic                            pc_j_en,
    input  logic                            stack_push,
    input  logic                            stack_pop,
    input  logic [4:0]                      pclath,
    input  logic [13:0]                     pm_data,
    output logic [PC_WIDTH-1:0]             pm_addr,
    output logic [PC_WIDTH-1:0]             pc,
    output logic [13:0]                     instr_current,
    output logic [$clog2(STACK_DEPTH):0]    stack_depth,
    output logic                            stack_overflow,
    output logic                            stack_underflow
);

    localparam int                  SP_W       = $clog2(STACK_DEPTH);
    localparam logic [SP_W-1:0]     SP_ONE     = 1;
    localparam logic [SP_W:0]       DEPTH_ONE  = 1;
    localparam logic [SP_W:0]       DEPTH_FULL = (SP_W+1)'(STACK_DEPTH);
    localparam logic [PC_WIDTH-1:0] PC_ONE     = 1;

    logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];
    logic [SP_W-1:0]     sp;
    logic [SP_W-1:0]     sp_dec;
    logic [PC_WIDTH-1:0] jump_target;

    assign pm_addr     = pc;
    assign sp_dec      = sp - SP_ONE;
    // Upper page bits come from PCLATH, the low 11 from the GOTO/CALL literal.
    assign jump_target = PC_WIDTH'({pclath[4:3], instr_current[10:0]});

    always_ff @(posedge clk) begin
        if (rst) begin
            pc              <= RESET_VECTOR;
            instr_current   <= 14'h0000;
            sp              <= '0;
            stack_depth     <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_mem[i] <= '0;
            end
        end else begin
            // Instruction register: flush beats read, otherwise hold.
            if (instr_flush) begin
                instr_current <= 14'h0000;
            end else if (instr_rd_en) begin
                instr_current <= pm_data;
            end

            if (stack_pop) begin
                // Pop always wraps sp and loads the entry, even when empty;
                // a concurrent push is dropped and flagged both ways.
                pc <= stack_mem[sp_dec];
                sp <= sp_dec;
                if (stack_depth != '0) begin
                    stack_depth <= stack_depth - DEPTH_ONE;
                end else begin
                    stack_underflow <= 1'b1;
                end
                if (stack_push) begin
                    stack_overflow  <= 1'b1;
                    stack_underflow <= 1'b1;
                end
            end else begin
                if (stack_push) begin
                    // Circular stack: a push when full overwrites the oldest entry.
                    stack_mem[sp] <= pc;
                    sp            <= sp + SP_ONE;
                    if (stack_depth == DEPTH_FULL) begin
                        stack_overflow <= 1'b1;
                    end else begin
                        stack_depth <= stack_depth + DEPTH_ONE;
                    end
                end
                if (pc_j_en) begin
                    pc <= jump_target;
                end else if (pc_incr_en) begin
                    pc <= pc + PC_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch

module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_rd_en, instr_flush, pc_incr_en, pc_j_en;
    logic        stack_push, stack_pop;
    logic [4:0]  pclath;
    logic [13:0] pm_data;
    logic [12:0] pm_addr, pc;
    logic [13:0] instr_current;
    logic [3:0]  stack_depth;
    logic        stack_overflow, stack_underflow;

    logic [13:0] mem [0:8191];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign pm_data = mem[pm_addr];

    instruction_fetch #(
        .PC_WIDTH    (13),
        .STACK_DEPTH (8),
        .RESET_VECTOR(13'h0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_rd_en    (instr_rd_en),
        .instr_flush    (instr_flush),
        .pc_incr_en     (pc_incr_en),
        .pc_j_en        (pc_j_en),
        .stack_push     (stack_push),
        .stack_pop      (stack_pop),
        .pclath         (pclath),
        .pm_data        (pm_data),
        .pm_addr        (pm_addr),
        .pc             (pc),
        .instr_current  (instr_current),
        .stack_depth    (stack_depth),
        .stack_overflow (stack_overflow),
        .stack_underflow(stack_underflow)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock edge with the currently driven controls, then release them.
    task automatic tick();
        @(posedge clk);
        #1;
        rst         = 1'b0;
        instr_rd_en = 1'b0;
        instr_flush = 1'b0;
        pc_incr_en  = 1'b0;
        pc_j_en     = 1'b0;
        stack_push  = 1'b0;
        stack_pop   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
    endtask

    // Load pc with a value on page 0 by reading a literal word and jumping to it.
    task automatic set_pc(input logic [12:0] target);
        mem[pc] = {3'b000, target[10:0]};
        pclath  = {target[12:11], 3'b000};
        instr_rd_en = 1'b1;
        tick();
        pc_j_en = 1'b1;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 14'(14'h3000 + i);
        rst = 1'b0; instr_rd_en = 1'b0; instr_flush = 1'b0; pc_incr_en = 1'b0;
        pc_j_en = 1'b0; stack_push = 1'b0; stack_pop = 1'b0; pclath = 5'b0;
        #2;

        // Reset with other controls active.
        instr_rd_en = 1'b1; pc_incr_en = 1'b1; stack_push = 1'b1;
        do_reset();
        check_vec("rst_pc", pc, 13'h0000);
        check_vec("rst_instr", instr_current, 14'h0000);
        check_vec("rst_depth", stack_depth, 4'd0);
        check_vec("rst_flags", {stack_overflow, stack_underflow}, 2'b00);
        check_vec("rst_pm_addr", pm_addr, 13'h0000);

        // Sequential fetch.
        for (int k = 1; k <= 4; k++) begin
            instr_rd_en = 1'b1; pc_incr_en = 1'b1;
            tick();
            check_vec("seq_instr", instr_current, 14'h3000 + 14'(k - 1));
            check_vec("seq_pc", pc, 13'(k));
        end
        instr_rd_en = 1'b1; pc_incr_en = 1'b1;
        do_reset();
        check_vec("midrst_pc", pc, 13'h0000);
        check_vec("midrst_instr", instr_current, 14'h0000);

        // GOTO with PCLATH page bits, then increment wrap.
        mem[0] = 14'h2A55;
        instr_rd_en = 1'b1;
        tick();
        check_vec("goto_fetch", instr_current, 14'h2A55);
        pclath = 5'b11000; pc_j_en = 1'b1; instr_flush = 1'b1;
        tick();
        check_vec("goto_pc", pc, 13'h1A55);
        check_vec("goto_flush", instr_current, 14'h0000);
        mem[13'h1A55] = 14'h07FF;
        instr_rd_en = 1'b1;
        tick();
        pc_j_en = 1'b1;
        tick();
        check_vec("goto_1fff", pc, 13'h1FFF);
        pc_incr_en = 1'b1;
        tick();
        check_vec("incr_wrap", pc, 13'h0000);

        // CALL / RETURN.
        do_reset();
        set_pc(13'h0105);
        check_vec("call_setup", pc, 13'h0105);
        mem[13'h0105] = 14'h2300;
        pclath = 5'b00000;
        instr_rd_en = 1'b1;
        tick();
        stack_push = 1'b1; pc_j_en = 1'b1; instr_flush = 1'b1;
        tick();
        check_vec("call_pc", pc, 13'h0300);
        check_vec("call_depth", stack_depth, 4'd1);
        pc_incr_en = 1'b1;
        tick();
        pc_incr_en = 1'b1;
        tick();
        stack_pop = 1'b1; pc_incr_en = 1'b1; pc_j_en = 1'b1;
        tick();
        check_vec("ret_pc", pc, 13'h0105);
        check_vec("ret_depth", stack_depth, 4'd0);
        check_vec("ret_flags", {stack_overflow, stack_underflow}, 2'b00);

        // Nine nested pushes, nine pops.
        do_reset();
        set_pc(13'h0010);
        for (int k = 0; k < 9; k++) begin
            stack_push = 1'b1; pc_incr_en = 1'b1;
            tick();
            if (k == 7) check_vec("push8_ovf", stack_overflow, 1'b0);
        end
        check_vec("push9_depth", stack_depth, 4'd8);
        check_vec("push9_ovf", stack_overflow, 1'b1);
        check_vec("push9_unf", stack_underflow, 1'b0);
        for (int k = 0; k < 8; k++) begin
            stack_pop = 1'b1;
            tick();
            check_vec("pop_pc", pc, 13'h0018 - 13'(k));
        end
        check_vec("pop8_depth", stack_depth, 4'd0);
        check_vec("pop8_unf", stack_underflow, 1'b0);
        stack_pop = 1'b1;
        tick();
        check_vec("pop9_pc", pc, 13'h0018);
        check_vec("pop9_unf", stack_underflow, 1'b1);
        check_vec("pop9_depth", stack_depth, 4'd0);

        // Reset clears stored entries: empty pop reads a zeroed slot.
        do_reset();
        stack_pop = 1'b1;
        tick();
        check_vec("clr_pop_pc", pc, 13'h0000);
        check_vec("clr_pop_unf", stack_underflow, 1'b1);

        // Skip: flush beats read while pc still advances.
        do_reset();
        mem[0] = 14'h3ABC;
        instr_rd_en = 1'b1;
        tick();
        check_vec("skip_pre", instr_current, 14'h3ABC);
        instr_rd_en = 1'b1; instr_flush = 1'b1; pc_incr_en = 1'b1;
        tick();
        check_vec("skip_instr", instr_current, 14'h0000);
        check_vec("skip_pc", pc, 13'h0001);

        // Simultaneous push and pop at depth 2.
        do_reset();
        stack_push = 1'b1; pc_incr_en = 1'b1;
        tick();
        stack_push = 1'b1; pc_incr_en = 1'b1;
        tick();
        check_vec("pp_depth2", stack_depth, 4'd2);
        stack_push = 1'b1; stack_pop = 1'b1;
        tick();
        check_vec("pp_pc", pc, 13'h0001);
        check_vec("pp_depth", stack_depth, 4'd1);
        check_vec("pp_flags", {stack_overflow, stack_underflow}, 2'b11);
        pc_incr_en = 1'b1;
        tick();
        stack_pop = 1'b1;
        tick();
        check_vec("pp_pop_pc", pc, 13'h0000);
        check_vec("pp_sticky", {stack_overflow, stack_underflow}, 2'b11);
        do_reset();
        check_vec("pp_rst_flags", {stack_overflow, stack_underflow}, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
